// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle for bin2bcd_seq: start/value in, ready/done/bcd/overflow out.
// The master side is the datapath result register, the slave side is the converter.
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      value;
    logic                  ready;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (
        output start,
        output value,
        input  ready,
        input  done,
        input  bcd,
        input  overflow
    );

    modport slave (
        input  start,
        input  value,
        output ready,
        output done,
        output bcd,
        output overflow
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock, with saturation.
// Define BIN2BCD_LZB_EN to replace leading zero digits with 4'hF (blank) at the final load.
module bin2bcd_seq #(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 3
) (
    input  logic              clk,
    input  logic              rst,
    bin2bcd_seq_if.slave      bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic {IDLE, CONV} state_t;

    state_t                state;
    state_t                stateNext;
    logic [CW-1:0]         count;
    logic [WIDTH-1:0]      shiftReg;
    logic [4*DIGITS-1:0]   work;
    logic                  sticky;

    logic [4*DIGITS-1:0]   adjusted;
    logic [4*DIGITS-1:0]   workNext;
    logic [WIDTH-1:0]      shiftNext;
    logic                  stickyNext;
    logic [4*DIGITS-1:0]   finalBcd;
    logic                  lastBit;

`ifdef BIN2BCD_LZB_EN
    // Digit 0 is never blanked so a zero result still shows a single 0.
    function automatic logic [4*DIGITS-1:0] blankLeading(input logic [4*DIGITS-1:0] w);
        logic [4*DIGITS-1:0] r;
        logic                seen;
        r    = w;
        seen = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (!seen && w[4*k +: 4] == 4'h0)
                r[4*k +: 4] = 4'hF;
            else
                seen = 1'b1;
        end
        return r;
    endfunction
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.start) stateNext = CONV;
            CONV:    if (lastBit)   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (state == IDLE);
    end

    // The bit shifted out of the top digit is lost precision, so it latches saturation.
    always_comb begin
        adjusted = work;
        for (int k = 0; k < DIGITS; k++) begin
            if (work[4*k +: 4] >= 4'd5)
                adjusted[4*k +: 4] = work[4*k +: 4] + 4'd3;
        end
        workNext   = {adjusted[4*DIGITS-2:0], shiftReg[WIDTH-1]};
        shiftNext  = shiftReg << 1;
        stickyNext = sticky | adjusted[4*DIGITS-1];
        lastBit    = (count == LAST_BIT);
`ifdef BIN2BCD_LZB_EN
        finalBcd   = stickyNext ? ALL_NINES : blankLeading(workNext);
`else
        finalBcd   = stickyNext ? ALL_NINES : workNext;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            shiftReg     <= '0;
            work         <= '0;
            sticky       <= 1'b0;
            bus.done     <= 1'b0;
            bus.bcd      <= '0;
            bus.overflow <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shiftReg <= bus.value;
                        work     <= '0;
                        sticky   <= 1'b0;
                        count    <= '0;
                    end
                end
                CONV: begin
                    shiftReg <= shiftNext;
                    work     <= workNext;
                    sticky   <= stickyNext;
                    if (lastBit) begin
                        count        <= '0;
                        bus.done     <= 1'b1;
                        bus.bcd      <= finalBcd;
                        bus.overflow <= stickyNext;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
